mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  E-stage pulse; qualifies md_op for one cycle.
REQ-006 md_op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
REQ-007 cancel  input  1  exception/interrupt flush of the E-stage instruction; suppresses the start seen that cycle.
REQ-008 A  input  32  rs operand (forwarded E-stage value).
REQ-009 B  input  32  rt operand (forwarded E-stage value).
REQ-010 busy  output  1  multi-cycle operation in progress; consumed by the hazard unit with start.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.

Function
REQ-013 States: IDLE, RUN; reset state IDLE; HI=0, LO=0, busy=0, counter=0.
REQ-014 Accepted start = start & !cancel & !busy; start with busy=1 or cancel=1 is ignored, no state change.
REQ-015 Accepted op 1-4: operands latched, result computed into pending hi/lo registers at that edge; IDLE->RUN; counter loaded with MULT_CYCLES or DIV_CYCLES.
REQ-016 busy=1 from the cycle after the accepting edge for exactly N cycles (N = loaded count), then 0.
REQ-017 Counter decrements each cycle in RUN; on the edge where it reaches 0, pending values commit to HI/LO, RUN->IDLE.
REQ-018 HI/LO hold previous values throughout RUN; new values visible from the first cycle busy=0.
REQ-019 Back-to-back: a start in the first cycle busy=0 is accepted normally.
REQ-020 mult: signed 32x32->64, HI=[63:32], LO=[31:0]; multu: unsigned.
REQ-021 div: signed, LO=quotient truncated toward zero, HI=remainder with sign of dividend; divu: unsigned.
REQ-022 Divide by zero (B=0, op 3/4): full busy latency, HI/LO unchanged at commit.
REQ-023 div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-024 mthi/mtlo accepted: HI (resp. LO) = A at that edge; busy stays 0; no RUN.
REQ-025 md_op 0 or 7 with start: no effect.
REQ-026 cancel has no effect on an operation already in RUN.

Reset
REQ-027 reset asserted at any time, including mid-RUN: immediate return to IDLE, busy=0, HI=LO=0, pending result discarded, counter=0.
REQ-028 First accepted start: the first rising edge with reset low.

Structure
REQ-029 Shared package holds md_op encodings and MULT_CYCLES/DIV_CYCLES defaults; decode in the control unit uses the same constants.
REQ-030 Single module; no sub-module; result computed with native operators; counter width = clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

Verification
REQ-031 mult A=0xFFFFFFFE(-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 divu A=100, B=7 -> busy high 10 cycles, then LO=14, HI=2; div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 div B=0 with HI=0x11, LO=0x22 preset via mthi/mtlo -> busy 10 cycles, HI=0x11, LO=0x22 after.
REQ-034 start with cancel=1, op=mult -> busy stays 0, HI/LO unchanged; start during busy -> ignored, first result only.
REQ-035 reset pulse at cycle 3 of a div -> busy=0 immediately, HI=LO=0, no later commit.
REQ-036 mthi A=0xDEADBEEF -> HI=0xDEADBEEF next cycle, busy never asserted; mult accepted the first cycle after busy falls -> runs normally.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_div_pkg;

  // md_op encodings, shared with the control-unit decoder.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  // Default busy latencies.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/mult_div_if.sv
// E-stage request / HI-LO result bundle between pipeline and mult_div.
// Latency: n/a (wiring only).
// Backpressure: busy tells the hazard unit to hold start.
interface mult_div_if;
  import mult_div_pkg::*;

  logic        start;
  logic        cancel;
  md_op_e      md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  // Pipeline side: issues operations, observes busy and HI/LO.
  modport master (
    output start, cancel, md_op, A, B,
    input  busy, HI, LO
  );

  // Unit side.
  modport slave (
    input  start, cancel, md_op, A, B,
    output busy, HI, LO
  );

endinterface

// File: rtl/mult_div.sv
// HI/LO multiply/divide unit: result computed at accept, committed after a fixed busy window.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES busy cycles; mthi/mtlo update next cycle.
// Backpressure: starts are ignored while busy; the hazard unit stalls on busy.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  mult_div_if.slave md
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  md_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]        r_hi, w_hi_nxt;
  logic [31:0]        r_lo, w_lo_nxt;
  logic [31:0]        r_phi, w_phi_nxt;   // pending HI
  logic [31:0]        r_plo, w_plo_nxt;   // pending LO
  logic               r_div0, w_div0_nxt; // pending result is a divide-by-zero: leave HI/LO alone

  logic               w_accept;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_a_mag, w_b_mag, w_b_safe_s, w_b_safe_u;
  logic [31:0]        w_q_mag, w_r_mag, w_q_s, w_r_s, w_q_u, w_r_u;

  assign w_accept = md.start & ~md.cancel & (r_state == ST_IDLE);

  // Datapath: products and quotients from native operators on the live operands.
  // Signed division works on magnitudes so that 0x80000000 / -1 has a defined
  // result (quotient 0x80000000, remainder 0). A zero divisor is replaced by 1
  // only to keep the divider defined; that result is never committed.
  always_comb begin
    w_prod_s   = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    w_prod_u   = {32'b0, md.A} * {32'b0, md.B};
    w_a_mag    = md.A[31] ? (32'd0 - md.A) : md.A;
    w_b_mag    = md.B[31] ? (32'd0 - md.B) : md.B;
    w_b_safe_s = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    w_b_safe_u = (md.B == 32'd0) ? 32'd1 : md.B;
    w_q_mag    = w_a_mag / w_b_safe_s;
    w_r_mag    = w_a_mag % w_b_safe_s;
    w_q_s      = (md.A[31] ^ md.B[31]) ? (32'd0 - w_q_mag) : w_q_mag;
    w_r_s      = md.A[31] ? (32'd0 - w_r_mag) : w_r_mag;
    w_q_u      = md.A / w_b_safe_u;
    w_r_u      = md.A % w_b_safe_u;
  end

  // Next-state / next-register decode for the IDLE/RUN controller.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_phi_nxt   = r_phi;
    w_plo_nxt   = r_plo;
    w_div0_nxt  = r_div0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (md.md_op)
            OP_MULT: begin
              w_phi_nxt   = w_prod_s[63:32];
              w_plo_nxt   = w_prod_s[31:0];
              w_div0_nxt  = 1'b0;
              w_cnt_nxt   = CNT_W'(MULT_CYCLES);
              w_state_nxt = ST_RUN;
            end
            OP_MULTU: begin
              w_phi_nxt   = w_prod_u[63:32];
              w_plo_nxt   = w_prod_u[31:0];
              w_div0_nxt  = 1'b0;
              w_cnt_nxt   = CNT_W'(MULT_CYCLES);
              w_state_nxt = ST_RUN;
            end
            OP_DIV: begin
              w_phi_nxt   = w_r_s;
              w_plo_nxt   = w_q_s;
              w_div0_nxt  = (md.B == 32'd0);
              w_cnt_nxt   = CNT_W'(DIV_CYCLES);
              w_state_nxt = ST_RUN;
            end
            OP_DIVU: begin
              w_phi_nxt   = w_r_u;
              w_plo_nxt   = w_q_u;
              w_div0_nxt  = (md.B == 32'd0);
              w_cnt_nxt   = CNT_W'(DIV_CYCLES);
              w_state_nxt = ST_RUN;
            end
            OP_MTHI: w_hi_nxt = md.A;
            OP_MTLO: w_lo_nxt = md.A;
            default: ; // none / reserved: no effect
          endcase
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          if (!r_div0) begin
            w_hi_nxt = r_phi;
            w_lo_nxt = r_plo;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counter, architectural and pending registers; reset discards any pending result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_phi   <= w_phi_nxt;
      r_plo   <= w_plo_nxt;
      r_div0  <= w_div0_nxt;
    end
  end

  assign md.busy = (r_state == ST_RUN);
  assign md.HI   = r_hi;
  assign md.LO   = r_lo;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed cases plus randomized ops against an arithmetic model.
// Latency: checks busy for exactly the configured cycle count per op.
// Backpressure: exercises starts issued while busy and with cancel.
module tb_mult_div;
  import mult_div_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_if md();

  mult_div #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted operation, from the arithmetic definition.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi_in, input logic [31:0] lo_in,
                        output logic [31:0] hi, output logic [31:0] lo, output int n);
    longint      sa, sb, q, r, p;
    logic [63:0] pu;
    hi = hi_in; lo = lo_in; n = 0;
    case (op)
      3'd1: begin
        sa = $signed(a); sb = $signed(b); p = sa * sb;
        pu = p; hi = pu[63:32]; lo = pu[31:0]; n = MC;
      end
      3'd2: begin
        pu = {32'd0, a} * {32'd0, b};
        hi = pu[63:32]; lo = pu[31:0]; n = MC;
      end
      3'd3: begin
        n = DC;
        if (b != 32'd0) begin
          sa = $signed(a); sb = $signed(b);
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
      3'd4: begin
        n = DC;
        if (b != 32'd0) begin
          lo = a / b; hi = a % b;
        end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endtask

  // Issue one op from a negedge in an idle cycle; follow it to the first idle cycle.
  // poke: while running, pulse a competing start, then raise cancel alone.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cxl, input bit poke);
    logic [31:0] nh, nl;
    int n;
    check("pre_busy", 32'(md.busy), 32'd0);
    md.start = 1'b1; md.md_op = md_op_e'(op); md.A = a; md.B = b; md.cancel = cxl;
    if (cxl) begin
      nh = m_hi; nl = m_lo; n = 0;
    end else begin
      ref_op(op, a, b, m_hi, m_lo, nh, nl, n);
    end
    @(negedge clk);
    md.start = 1'b0; md.cancel = 1'b0; md.A = $urandom; md.B = $urandom;
    for (int k = 0; k < n; k++) begin
      check("run_busy", 32'(md.busy), 32'd1);
      check("run_hi", md.HI, m_hi);
      check("run_lo", md.LO, m_lo);
      md.start = 1'b0; md.cancel = 1'b0;
      if (poke && k == 1) begin
        md.start = 1'b1; md.md_op = OP_DIVU; md.A = 32'd1; md.B = 32'd1;
      end
      if (poke && k == 3) md.cancel = 1'b1;
      @(negedge clk);
    end
    md.start = 1'b0; md.cancel = 1'b0;
    m_hi = nh; m_lo = nl;
    check("done_busy", 32'(md.busy), 32'd0);
    check("done_hi", md.HI, m_hi);
    check("done_lo", md.LO, m_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        cxl;

    reset = 1'b1;
    md.start = 1'b0; md.cancel = 1'b0; md.md_op = OP_NONE; md.A = '0; md.B = '0;

    @(negedge clk);
    check("rst_busy", 32'(md.busy), 32'd0);
    check("rst_hi", md.HI, 32'd0);
    check("rst_lo", md.LO, 32'd0);
    reset = 1'b0;

    // mult -2 * 3, issued in the first cycle after reset release
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    check("mult_hi_const", md.HI, 32'hFFFFFFFF);
    check("mult_lo_const", md.LO, 32'hFFFFFFFA);

    // divu 100 / 7, then signed -7 / 2
    run_op(3'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    check("divu_lo_const", md.LO, 32'd14);
    check("divu_hi_const", md.HI, 32'd2);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check("div_lo_const", md.LO, 32'hFFFFFFFD);
    check("div_hi_const", md.HI, 32'hFFFFFFFF);

    // preset HI/LO, then divide by zero leaves them alone
    run_op(3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
    run_op(3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
    run_op(3'd3, 32'd12345, 32'd0, 1'b0, 1'b0);
    check("div0_hi_const", md.HI, 32'h11);
    check("div0_lo_const", md.LO, 32'h22);
    run_op(3'd4, 32'd999, 32'd0, 1'b0, 1'b0);

    // cancelled mult is ignored; start and cancel during a mult do not disturb it
    run_op(3'd1, 32'd7, 32'd9, 1'b1, 1'b0);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    check("multu_hi_const", md.HI, 32'hFFFFFFFE);
    check("multu_lo_const", md.LO, 32'h00000001);

    // mthi then back-to-back mults
    run_op(3'd5, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
    check("mthi_const", md.HI, 32'hDEADBEEF);
    run_op(3'd1, 32'h00010000, 32'h00010000, 1'b0, 1'b0);
    run_op(3'd1, 32'h80000000, 32'h80000000, 1'b0, 1'b0);

    // overflow corner, then no-op encodings
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("ovf_lo_const", md.LO, 32'h80000000);
    check("ovf_hi_const", md.HI, 32'd0);
    run_op(3'd0, 32'h5555, 32'h6666, 1'b0, 1'b0);
    run_op(3'd7, 32'h5555, 32'h6666, 1'b0, 1'b0);

    // reset in the third busy cycle of a div: immediate clear, no later commit
    run_op(3'd5, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);
    md.start = 1'b1; md.md_op = OP_DIV; md.A = 32'd1000; md.B = 32'd3; md.cancel = 1'b0;
    @(negedge clk);
    md.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("prerst_busy", 32'(md.busy), 32'd1);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(md.busy), 32'd0);
    check("midrst_hi", md.HI, 32'd0);
    check("midrst_lo", md.LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < DC + 2; k++) begin
      check("postrst_busy", 32'(md.busy), 32'd0);
      check("postrst_hi", md.HI, 32'd0);
      check("postrst_lo", md.LO, 32'd0);
      @(negedge clk);
    end

    // randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 32'h80000000;
        1:       a = 32'd0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      cxl = ($urandom_range(0, 9) == 0);
      run_op(op, a, b, cxl, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
